// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default feedback mask, the Fibonacci step function
// used by both the generator and the checker, and the checker state encoding.
package lfsr_pkg;

  // x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0)
  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // One Fibonacci step on a word of 'width' bits (width <= 64): shift left and
  // insert the parity of the tapped bits at bit 0. Bits above 'width' are
  // cleared so callers can truncate the result back to their own width.
  function automatic logic [63:0] nxt(input logic [63:0] s,
                                      input logic [63:0] taps,
                                      input int          width);
    logic [63:0] mask;
    logic        fb;
    if (width >= 64) mask = '1;
    else             mask = (64'd1 << width) - 64'd1;
    fb  = ^(s & taps & mask);
    nxt = ((s << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over
// an increment in the same cycle.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, hold at all-ones, clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker. Seeds its predictor from the first nonzero word,
// confirms LOCK_CNT consecutive predictions before declaring lock, then counts
// words and mismatches until LOSS_CNT consecutive mismatches drop the lock.
//
// Input handshake: in_valid qualifies in_data for exactly the cycle it is high;
// there is no ready, the checker accepts every valid word on the rising edge.
// Cycles with in_valid low leave the FSM, predictor and run counter untouched.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 32,   // 3..64
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS),
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 3,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output lfsr_state_e      state_dbg
);

  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  lfsr_state_e      state, state_nxt;
  logic [WIDTH-1:0] pred, pred_nxt;
  logic [RUN_W-1:0] run, run_nxt, run_inc;
  logic [WIDTH-1:0] step_w, step_p;
  logic             err_nxt, err_inc, word_inc;
  logic             match, nonzero;

  assign step_w  = WIDTH'(nxt(64'(in_data), 64'(TAPS), WIDTH));
  assign step_p  = WIDTH'(nxt(64'(pred),    64'(TAPS), WIDTH));
  assign run_inc = run + 1'b1;
  assign match   = (in_data == pred);
  assign nonzero = (in_data != '0);

  // State, predictor, run length and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      pred      <= '0;
      run       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      pred      <= pred_nxt;
      run       <= run_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_nxt;
    end
  end

  // Next-state logic: seeding, verification and lock maintenance.
  always_comb begin
    state_nxt = state;
    pred_nxt  = pred;
    run_nxt   = run;
    err_nxt   = 1'b0;
    err_inc   = 1'b0;
    word_inc  = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          // An all-zero word is the LFSR lockup value and cannot seed.
          if (nonzero) begin
            pred_nxt  = step_w;
            run_nxt   = '0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            pred_nxt = step_w;
            if (run_inc == RUN_W'(LOCK_CNT)) begin
              run_nxt   = '0;
              state_nxt = LOCKED;
            end else begin
              run_nxt = run_inc;
            end
          end else if (nonzero) begin
            // Reseed from the new word and restart the match run.
            pred_nxt = step_w;
            run_nxt  = '0;
          end else begin
            run_nxt   = '0;
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Free-run the predictor so a single corrupted word is not copied
          // into the following predictions.
          pred_nxt = step_p;
          word_inc = 1'b1;
          if (match) begin
            run_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            err_inc = 1'b1;
            if (run_inc == RUN_W'(LOSS_CNT)) begin
              run_nxt   = '0;
              state_nxt = HUNT;
            end else begin
              run_nxt = run_inc;
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          run_nxt   = '0;
        end
      endcase
    end
  end

  assign state_dbg = state;

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (clr_cnt),
    .cnt   (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (word_inc),
    .clr   (clr_cnt),
    .cnt   (word_cnt)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed lock/error/loss/reset scenarios plus a
// randomized stream, all compared against a behavioural reference model.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic        a_valid = 1'b0;
  logic [31:0] a_data  = '0;
  logic        a_clr   = 1'b0;
  logic        a_locked, a_pulse;
  logic [15:0] a_err, a_words;
  lfsr_state_e a_state;

  // Instance B: 4-bit counters and a loss threshold that is never reached.
  logic        b_valid = 1'b0;
  logic [31:0] b_data  = '0;
  logic        b_clr   = 1'b0;
  logic        b_locked, b_pulse;
  logic [3:0]  b_err, b_words;
  lfsr_state_e b_state;

  lfsr_checker u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data), .clr_cnt(a_clr),
    .locked(a_locked), .err_pulse(a_pulse), .err_cnt(a_err), .word_cnt(a_words),
    .state_dbg(a_state)
  );

  lfsr_checker #(.CNT_W(4), .LOSS_CNT(200)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data), .clr_cnt(b_clr),
    .locked(b_locked), .err_pulse(b_pulse), .err_cnt(b_err), .word_cnt(b_words),
    .state_dbg(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Next LFSR word: double the value (dropping the top bit) and add the
  // parity of the tapped bits, counted one by one.
  function automatic logic [31:0] ref_nxt(input logic [31:0] s);
    int ones = 0;
    for (int i = 0; i < 32; i++) if (TAPS[i] && s[i]) ones++;
    return (s * 2) + 32'(ones % 2);
  endfunction

  // Model of instance A: phase 0 = hunting, 1 = confirming, 2 = locked.
  int          m_phase;
  logic [31:0] m_pred;
  int          m_run;
  bit          m_pulse;
  int          m_err, m_words;

  task automatic model_reset();
    m_phase = 0; m_pred = '0; m_run = 0; m_pulse = 0; m_err = 0; m_words = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] w, input bit clr);
    m_pulse = 0;
    if (v) begin
      if (m_phase == 0) begin
        if (w != 0) begin m_pred = ref_nxt(w); m_run = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (w == m_pred) begin
          m_pred = ref_nxt(w);
          m_run  = m_run + 1;
          if (m_run == 4) begin m_phase = 2; m_run = 0; end
        end else if (w != 0) begin
          m_pred = ref_nxt(w); m_run = 0;
        end else begin
          m_phase = 0; m_run = 0;
        end
      end else begin
        if (m_words < 65535) m_words++;
        if (w == m_pred) m_run = 0;
        else begin
          m_pulse = 1;
          if (m_err < 65535) m_err++;
          m_run = m_run + 1;
          if (m_run == 3) begin m_phase = 0; m_run = 0; end
        end
        m_pred = ref_nxt(m_pred);
      end
    end
    if (clr) begin m_err = 0; m_words = 0; end
  endtask

  task automatic compare_a(input string tag);
    lfsr_state_e es;
    es = (m_phase == 0) ? HUNT : (m_phase == 1) ? VERIFY : LOCKED;
    check({tag, ".locked"}, 64'(a_locked), 64'(m_phase == 2));
    check({tag, ".err_pulse"}, 64'(a_pulse), 64'(m_pulse));
    check({tag, ".err_cnt"}, 64'(a_err), 64'(m_err));
    check({tag, ".word_cnt"}, 64'(a_words), 64'(m_words));
    check({tag, ".state"}, 64'(a_state), 64'(es));
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] src;  // source LFSR for instance A

  task automatic drive_a(input string tag, input bit v, input logic [31:0] w, input bit clr);
    @(negedge clk);
    a_valid = v; a_data = w; a_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, w, clr);
    compare_a(tag);
  endtask

  // Send one word from the source, optionally with one bit flipped.
  task automatic send_src(input string tag, input bit corrupt, input int bitpos);
    logic [31:0] w;
    w = corrupt ? (src ^ (32'd1 << bitpos)) : src;
    drive_a(tag, 1'b1, w, 1'b0);
    src = ref_nxt(src);
  endtask

  task automatic drive_b(input bit v, input logic [31:0] w, input bit clr);
    @(negedge clk);
    b_valid = v; b_data = w; b_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] bsrc;
    int nv;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // Reset state observed while rst_n is still low.
    compare_a("reset");
    check("reset.b_locked", 64'(b_locked), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Instance B: lock, then continuous errors saturate at 15; clear wins.
    bsrc = 32'h1;
    for (int i = 0; i < 5; i++) begin drive_b(1'b1, bsrc, 1'b0); bsrc = ref_nxt(bsrc); end
    check("b.lock", 64'(b_locked), 64'd1);
    check("b.lock_state", 64'(b_state), 64'(LOCKED));
    for (int i = 1; i <= 20; i++) begin
      drive_b(1'b1, bsrc ^ 32'h10, 1'b0);
      bsrc = ref_nxt(bsrc);
      check("b.err_sat", 64'(b_err), 64'((i > 15) ? 15 : i));
      check("b.pulse", 64'(b_pulse), 64'd1);
    end
    check("b.word_sat", 64'(b_words), 64'd15);
    check("b.still_locked", 64'(b_locked), 64'd1);
    drive_b(1'b1, bsrc ^ 32'h10, 1'b1);
    bsrc = ref_nxt(bsrc);
    check("b.clr_err", 64'(b_err), 64'd0);
    check("b.clr_words", 64'(b_words), 64'd0);
    drive_b(1'b0, '0, 1'b0);

    // 1: clean stream seeded with 1 locks on the 5th word.
    src = 32'h1;
    for (int i = 1; i <= 5; i++) begin
      send_src("t1", 1'b0, 0);
      check("t1.lock_timing", 64'(a_locked), 64'(i == 5));
    end
    for (int i = 1; i <= 3; i++) begin
      send_src("t1w", 1'b0, 0);
      check("t1.word_cnt", 64'(a_words), 64'(i));
    end
    check("t1.err_cnt", 64'(a_err), 64'd0);

    // 2: one word with bit 7 flipped, no propagation afterwards.
    send_src("t2bad", 1'b1, 7);
    check("t2.pulse", 64'(a_pulse), 64'd1);
    check("t2.err_cnt", 64'(a_err), 64'd1);
    check("t2.locked", 64'(a_locked), 64'd1);
    for (int i = 0; i < 4; i++) begin
      send_src("t2ok", 1'b0, 0);
      check("t2.no_prop_pulse", 64'(a_pulse), 64'd0);
      check("t2.no_prop_err", 64'(a_err), 64'd1);
    end

    // 3: three consecutive bad words drop lock; a clean stream relocks.
    drive_a("t3clr", 1'b0, '0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      send_src("t3bad", 1'b1, i);
      check("t3.locked", 64'(a_locked), 64'(i < 3));
    end
    check("t3.err_cnt", 64'(a_err), 64'd3);
    for (int i = 1; i <= 5; i++) begin
      send_src("t3re", 1'b0, 0);
      check("t3.relock", 64'(a_locked), 64'(i == 5));
    end

    // 6: asynchronous reset between edges while locked.
    send_src("t6pre", 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6.locked", 64'(a_locked), 64'd0);
    check("t6.err_cnt", 64'(a_err), 64'd0);
    check("t6.word_cnt", 64'(a_words), 64'd0);
    check("t6.state", 64'(a_state), 64'(HUNT));
    @(negedge clk);
    rst_n = 1'b1;

    // 4: all-zero words never seed.
    for (int i = 0; i < 6; i++) drive_a("t4zero", 1'b1, '0, 1'b0);
    check("t4.hunt", 64'(a_state), 64'(HUNT));
    check("t4.locked", 64'(a_locked), 64'd0);

    // 4: random valid gaps, lock counted in valid words only.
    src = $urandom() | 32'h1;
    nv = 0;
    while (nv < 8) begin
      if ($urandom_range(0, 2) == 0) begin
        drive_a("t4gap", 1'b0, $urandom(), 1'b0);
      end else begin
        send_src("t4val", 1'b0, 0);
        nv++;
      end
      check("t4.gap_lock", 64'(a_locked), 64'(nv >= 5));
    end

    // Randomized stream: gaps, bit errors, zero words and clears.
    for (int i = 0; i < 400; i++) begin
      bit v, clr;
      int kind;
      logic [31:0] w;
      v    = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 31) == 0);
      kind = $urandom_range(0, 39);
      if (kind == 0)      w = '0;
      else if (kind < 6)  w = src ^ (32'd1 << $urandom_range(0, 31));
      else                w = src;
      drive_a("rand", v, v ? w : $urandom(), clr);
      if (v) src = ref_nxt(src);
      if ($urandom_range(0, 99) == 0) src = $urandom() | 32'h1;
    end

    a_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
